mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one backing-memory request port among NUM_CH core requesters (ch0 = icache, ch1 = dcache by default).
//  Arbitrates requests, tracks up to OUTST in-flight requests in order, routes each response to its owner.
//  Per-channel flush discards stale responses, e.g. icache fetches killed by a branch redirect.
//  Sits between the core top level and the SoC memory/bus bridge.
// PARAMETERS
//  NUM_CH    2   number of requesting channels (>=2)
//  ADDR_W    64  request address width
//  DATA_W    64  write/read data width
//  OUTST     4   max outstanding requests (power of 2, >=2)
//  ARB_MODE  1   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 asynchronous active-low reset
//  ch_req_valid_i   in   NUM_CH            per-channel request valid
//  ch_req_ready_o   out  NUM_CH            request accepted this cycle (one-hot or zero)
//  ch_addr_i        in   NUM_CH*ADDR_W     per-channel address, ch i at [i*ADDR_W +: ADDR_W]
//  ch_wen_i         in   NUM_CH            per-channel write enable
//  ch_wdata_i       in   NUM_CH*DATA_W     per-channel write data
//  ch_wlen_i        in   NUM_CH*2          per-channel access size (0=B,1=H,2=W,3=D)
//  ch_flush_i       in   NUM_CH            discard all older outstanding responses of channel
//  ch_rsp_valid_o   out  NUM_CH            response valid, one-hot
//  ch_rsp_data_o    out  DATA_W            response data (shared, qualified by ch_rsp_valid_o)
//  mem_req_valid_o  out  1                 downstream request valid
//  mem_req_ready_i  in   1                 downstream accepts request
//  mem_addr_o / mem_wen_o / mem_wdata_o / mem_wlen_o  out  ADDR_W/1/DATA_W/2  staged request
//  mem_rsp_valid_i  in   1                 downstream response valid (in order, one per request, writes too)
//  mem_rsp_data_i   in   DATA_W            downstream response data (don't-care for writes)
//  err_o            out  1                 sticky: response received with nothing outstanding
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, staging register empty, ID FIFO empty, RR pointer = 0, err_o = 0.
//  Accept: channel granted when ch_req_valid_i set, staging reg empty or draining (mem_req_ready_i
//   high this cycle), and in_flight + staged < OUTST; ch_req_ready_o = grant, combinational.
//  Fixed mode: lowest valid index wins. RR: search from pointer; after grant i, pointer = (i+1) mod NUM_CH.
//   No grant -> pointer holds.
//  Latency: grant at edge N -> mem_req_valid_o high from N+1; holds stable until mem_req_ready_i.
//  Downstream handshake: staged request leaves on valid&ready; its channel ID and drop=0 are pushed
//   to the ID FIFO at that edge.
//  Response: mem_rsp_valid_i at edge M pops FIFO head; if drop=0, ch_rsp_valid_o[id] high for exactly
//   one cycle from M+1 with registered data; if drop=1, consumed silently.
//  Flush: ch_flush_i[c] sets drop on every FIFO entry with id c and on the staged request if of channel c
//   (issued downstream, response dropped). A request granted to c in the same cycle is not dropped.
//  Simultaneous push and pop: both occur, occupancy unchanged. Flush and pop of same entry: entry dropped.
//  Response with FIFO empty: ignored, err_o set until reset.
//  Full: in_flight + staged = OUTST -> no grants; ch_req_ready_o all 0.
//  Response can never return in the cycle its request is handed downstream (>=1 cycle memory latency).
//  Reset mid-operation: all tracking lost; a late downstream response after reset sets err_o.
//  Widths: ID width = max(1,$clog2(NUM_CH)); count width $clog2(OUTST)+1; pointers wrap modulo OUTST.
// STRUCTURE
//  defines.v gains: `ARB_FIXED 0, `ARB_RR 1, `WLEN_B/H/W/D encodings shared with dcache and MEM stage.
//  One sub-module: arb_id_fifo (sync FIFO, width ID+1 drop bit, depth OUTST, exposes per-entry drop set
//   by channel mask, async active-low reset). Arbiter, staging reg, response mux in this module.
// TESTING
//  1. Reset, ch1 alone: addr=0x8000_0010, wen=1, wdata=0xDEAD, wlen=3 -> mem_req fields match
//     next cycle; rsp -> ch_rsp_valid_o=2'b10 one cycle.
//  2. RR, both channels valid 6 cycles, mem_req_ready_i=1 -> grants alternate 0,1,0,1,0,1;
//     ARB_MODE=0 -> ch0 every cycle.
//  3. mem_rsp withheld, ch0 streams -> exactly 4 grants (OUTST=4), ready 0 until first
//     rsp, then one more grant.
//  4. ch0 issues 3 reads, ch_flush_i=01 pulse, ch1 read granted same cycle -> 3 ch0 responses
//     dropped, ch1 response delivered data 0x1234.
//  5. mem_req_ready_i low 5 cycles -> staged addr/wdata stable, no new grants; no ch_rsp.
//  6. mem_rsp_valid_i with FIFO empty -> no ch_rsp_valid_o, err_o=1 stays until rst low;
//     rst low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: arbitration modes,
// access-size encodings and the channel-ID width helper.
package mem_port_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Access size encodings shared with the dcache and MEM stage.
    localparam logic [1:0] WLEN_B = 2'd0;
    localparam logic [1:0] WLEN_H = 2'd1;
    localparam logic [1:0] WLEN_W = 2'd2;
    localparam logic [1:0] WLEN_D = 2'd3;

    // Channel ID width: max(1, clog2(n)).
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of {drop, channel id} for requests issued downstream.
// Any entry can be marked "drop" by a per-channel mask; the head's drop
// flag already reflects a mask arriving in the same cycle as the pop.
module arb_id_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int ID_W   = 1,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [ID_W-1:0]          push_id_i,
    input  logic                     push_drop_i,
    input  logic                     pop_i,
    input  logic [NUM_CH-1:0]        drop_mask_i,
    output logic [ID_W-1:0]          head_id_o,
    output logic                     head_drop_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  id_q [DEPTH];
    logic [DEPTH-1:0] drop_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [DEPTH-1:0] hit;

    // Entries whose owning channel is being flushed this cycle.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (drop_mask_i[c] && id_q[i] == ID_W'(c)) hit[i] = 1'b1;
            end
        end
    end

    assign head_id_o   = id_q[rd_ptr_q];
    assign head_drop_o = drop_q[rd_ptr_q] | hit[rd_ptr_q];
    assign count_o     = count_q;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
        end else begin
            drop_q <= drop_q | hit;
            if (push_i) begin
                id_q[wr_ptr_q]   <= push_id_i;
                drop_q[wr_ptr_q] <= push_drop_i;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory request port among NUM_CH requesters.
// Arbitration -> one-entry staging register -> downstream; issued requests
// are tracked in order so each response returns to its owner, or is
// silently discarded when the owner flushed it.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int OUTST    = 4,
    parameter int ARB_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req_valid_i,
    output logic [NUM_CH-1:0]        ch_req_ready_o,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH-1:0]        ch_wen_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
    input  logic [NUM_CH*2-1:0]      ch_wlen_i,
    input  logic [NUM_CH-1:0]        ch_flush_i,
    output logic [NUM_CH-1:0]        ch_rsp_valid_o,
    output logic [DATA_W-1:0]        ch_rsp_data_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic                     mem_wen_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic [1:0]               mem_wlen_o,
    input  logic                     mem_rsp_valid_i,
    input  logic [DATA_W-1:0]        mem_rsp_data_i,
    output logic                     err_o
);

    localparam int ID_W  = id_width(NUM_CH);
    localparam int CNT_W = $clog2(OUTST) + 1;

    logic [CNT_W-1:0]  fifo_count;
    logic [ID_W-1:0]   head_id;
    logic              head_drop;
    logic              can_accept;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    int                idx;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              stg_valid_q, stg_wen_q, stg_drop_q;
    logic [ID_W-1:0]   stg_id_q;
    logic [ADDR_W-1:0] stg_addr_q;
    logic [DATA_W-1:0] stg_wdata_q;
    logic [1:0]        stg_wlen_q;
    logic              stg_flush_hit;
    logic              drain, pop;
    logic [NUM_CH-1:0] rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_q;

    // Room for a new request: staging slot free (or leaving now) and the
    // in-flight plus staged total below the limit. Held off during reset.
    assign can_accept = rst && (!stg_valid_q || mem_req_ready_i) &&
                        ((fifo_count + CNT_W'(stg_valid_q)) < CNT_W'(OUTST));

    // Pick a winner: lowest index in fixed mode, search from pointer in RR.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == ARB_RR) idx = (int'(rr_ptr_q) + k) % NUM_CH;
            else                    idx = k;
            if (can_accept && !grant_valid && ch_req_valid_i[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign ch_req_ready_o = grant_valid ? (NUM_CH'(1) << grant_id) : '0;
    assign rr_ptr_d       = (int'(grant_id) == NUM_CH - 1) ? '0 : grant_id + 1'b1;

    // Round-robin pointer advances past the winner; holds without a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             rr_ptr_q <= '0;
        else if (grant_valid) rr_ptr_q <= rr_ptr_d;
    end

    // Does this cycle's flush hit the staged request's channel?
    always_comb begin
        stg_flush_hit = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_flush_i[c] && stg_id_q == ID_W'(c)) stg_flush_hit = 1'b1;
        end
    end

    assign drain = stg_valid_q && mem_req_ready_i;
    assign pop   = mem_rsp_valid_i && (fifo_count != '0);

    // Staging register: loaded on grant, emptied on handshake. A flushed
    // staged request still goes downstream but its response is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_valid_q <= 1'b0;
            stg_wen_q   <= 1'b0;
            stg_drop_q  <= 1'b0;
            stg_id_q    <= '0;
            stg_addr_q  <= '0;
            stg_wdata_q <= '0;
            stg_wlen_q  <= '0;
        end else if (grant_valid) begin
            stg_valid_q <= 1'b1;
            stg_id_q    <= grant_id;
            stg_drop_q  <= 1'b0;
            stg_addr_q  <= ch_addr_i[grant_id*ADDR_W +: ADDR_W];
            stg_wen_q   <= ch_wen_i[grant_id];
            stg_wdata_q <= ch_wdata_i[grant_id*DATA_W +: DATA_W];
            stg_wlen_q  <= ch_wlen_i[grant_id*2 +: 2];
        end else if (drain) begin
            stg_valid_q <= 1'b0;
        end else if (stg_valid_q && stg_flush_hit) begin
            stg_drop_q  <= 1'b1;
        end
    end

    assign mem_req_valid_o = stg_valid_q;
    assign mem_addr_o      = stg_addr_q;
    assign mem_wen_o       = stg_wen_q;
    assign mem_wdata_o     = stg_wdata_q;
    assign mem_wlen_o      = stg_wlen_q;

    arb_id_fifo #(
        .ID_W   (ID_W),
        .DEPTH  (OUTST),
        .NUM_CH (NUM_CH)
    ) u_id_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (drain),
        .push_id_i   (stg_id_q),
        .push_drop_i (stg_drop_q | stg_flush_hit),
        .pop_i       (pop),
        .drop_mask_i (ch_flush_i),
        .head_id_o   (head_id),
        .head_drop_o (head_drop),
        .count_o     (fifo_count)
    );

    // Route responses to the head owner for one cycle; flag orphans.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (pop) begin
                rsp_data_q <= mem_rsp_data_i;
                if (!head_drop) rsp_valid_q <= NUM_CH'(1) << head_id;
            end
            if (mem_rsp_valid_i && fifo_count == '0) err_q <= 1'b1;
        end
    end

    assign ch_rsp_valid_o = rsp_valid_q;
    assign ch_rsp_data_o  = rsp_data_q;
    assign err_o          = err_q;

endmodule
